// File: rtl/fifo_line_rd_stream.sv
// Read-side drain engine: issues FIFO reads, absorbs RAM latency in a small skid
// buffer and presents a valid/ready stream with per-line framing and line counting.
module fifo_line_rd_stream #(
   parameter int c_DATA_WIDTH = 1,
   parameter int c_RD_LATENCY = 1,
   parameter int c_LINE_LEN   = 1280,
   parameter int c_BEAT_WIDTH = 11
) (
   input  logic                    rclk,
   input  logic                    rrst_n,
   input  logic                    rempty,
   output logic                    r_en,
   input  logic [c_DATA_WIDTH-1:0] rdata,
   input  logic                    frame_start,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [c_DATA_WIDTH-1:0] m_data,
   output logic                    m_last,
   output logic                    line_done,
   output logic [15:0]             line_cnt
);

   localparam int c_DEPTH = c_RD_LATENCY + 2;
   localparam int c_PTR_W = $clog2(c_DEPTH);
   localparam int c_CNT_W = $clog2(c_DEPTH + 1);
   localparam logic [c_PTR_W-1:0]      c_PTR_LAST  = c_PTR_W'(c_DEPTH - 1);
   localparam logic [c_PTR_W-1:0]      c_PTR_ONE   = c_PTR_W'(1);
   localparam logic [c_CNT_W-1:0]      c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [c_CNT_W:0]        c_OCC_DEPTH = (c_CNT_W + 1)'(c_DEPTH);
   localparam logic [c_BEAT_WIDTH-1:0] c_BEAT_LAST = c_BEAT_WIDTH'(c_LINE_LEN - 1);
   localparam logic [c_BEAT_WIDTH-1:0] c_BEAT_ONE  = c_BEAT_WIDTH'(1);

   function automatic logic [c_CNT_W-1:0] popcount(input logic [c_RD_LATENCY-1:0] v);
      logic [c_CNT_W-1:0] n;
      n = {c_CNT_W{1'b0}};
      for (int i = 0; i < c_RD_LATENCY; i++) begin
         n = n + c_CNT_W'(v[i]);
      end
      return n;
   endfunction

   function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_LAST) ? {c_PTR_W{1'b0}} : p + c_PTR_ONE;
   endfunction

   logic [c_RD_LATENCY-1:0] trk_r;
   logic [c_RD_LATENCY-1:0] trk_nxt_s;
   logic [c_DATA_WIDTH-1:0] skid_r [c_DEPTH];
   logic [c_PTR_W-1:0]      wr_ptr_r;
   logic [c_PTR_W-1:0]      rd_ptr_r;
   logic [c_CNT_W-1:0]      count_r;
   logic [c_CNT_W-1:0]      count_nxt_s;
   logic [c_CNT_W-1:0]      inflight_s;
   logic [c_CNT_W:0]        occ_s;
   logic [c_BEAT_WIDTH-1:0] beat_r;
   logic [c_BEAT_WIDTH-1:0] beat_nxt_s;
   logic [15:0]             line_cnt_r;
   logic [15:0]             line_cnt_nxt_s;
   logic                    line_done_r;
   logic                    line_done_nxt_s;
   logic                    push_s;
   logic                    pop_s;

   // Reads in flight plus buffered words never exceed the skid depth, so no overflow.
   assign inflight_s = popcount(trk_r);
   assign occ_s      = {1'b0, count_r} + {1'b0, inflight_s};
   assign r_en       = rrst_n && !rempty && (occ_s < c_OCC_DEPTH);
   assign push_s     = trk_r[c_RD_LATENCY-1];
   assign pop_s      = m_valid && m_ready;
   assign trk_nxt_s  = (trk_r << 1'b1) | c_RD_LATENCY'(r_en);

   assign m_valid   = (count_r != {c_CNT_W{1'b0}});
   assign m_data    = skid_r[rd_ptr_r];
   assign m_last    = m_valid && (beat_r == c_BEAT_LAST);
   assign line_done = line_done_r;
   assign line_cnt  = line_cnt_r;

   // Skid occupancy next state from push/pop.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + c_CNT_ONE;
         2'b01:   count_nxt_s = count_r - c_CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Beat/line framing next state; frame_start wins over a simultaneous pop.
   always_comb begin
      beat_nxt_s      = beat_r;
      line_cnt_nxt_s  = line_cnt_r;
      line_done_nxt_s = 1'b0;
      if (frame_start) begin
         beat_nxt_s     = {c_BEAT_WIDTH{1'b0}};
         line_cnt_nxt_s = 16'd0;
      end else if (pop_s) begin
         if (beat_r == c_BEAT_LAST) begin
            beat_nxt_s      = {c_BEAT_WIDTH{1'b0}};
            line_cnt_nxt_s  = line_cnt_r + 16'd1;
            line_done_nxt_s = 1'b1;
         end else begin
            beat_nxt_s = beat_r + c_BEAT_ONE;
         end
      end else begin
         beat_nxt_s = beat_r;
      end
   end

   // Control state: tracker, pointers, occupancy and framing counters.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         trk_r       <= {c_RD_LATENCY{1'b0}};
         wr_ptr_r    <= {c_PTR_W{1'b0}};
         rd_ptr_r    <= {c_PTR_W{1'b0}};
         count_r     <= {c_CNT_W{1'b0}};
         beat_r      <= {c_BEAT_WIDTH{1'b0}};
         line_cnt_r  <= 16'd0;
         line_done_r <= 1'b0;
      end else begin
         trk_r       <= trk_nxt_s;
         count_r     <= count_nxt_s;
         beat_r      <= beat_nxt_s;
         line_cnt_r  <= line_cnt_nxt_s;
         line_done_r <= line_done_nxt_s;
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
      end
   end

   // Skid storage is data-only; validity comes from count_r.
   always_ff @(posedge rclk) begin
      if (push_s) begin
         skid_r[wr_ptr_r] <= rdata;
      end
   end

endmodule

// File: tb/tb_fifo_line_rd_stream.sv
// Scoreboard bench: two instances (read latency 1 and 2, line length 4) fed from a FIFO/RAM model.
module tb_fifo_line_rd_stream;

   localparam int LL = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rrst_n;
   logic        frame_start;
   logic        m_ready;
   logic        hold_empty;
   logic [1:0]  rempty;
   logic [1:0]  r_en;
   logic [1:0]  m_valid;
   logic [1:0]  m_last;
   logic [1:0]  line_done;
   logic [7:0]  rdata [2];
   logic [7:0]  m_data [2];
   logic [15:0] line_cnt [2];

   logic [7:0]  mem [0:255];
   int          wr_idx = 0;
   int          rd_idx [2] = '{0, 0};
   logic [7:0]  p1 [2];
   logic [7:0]  p2 [2];
   int          ser = 16;

   logic [7:0]  q0 [$];
   logic [7:0]  q1 [$];

   int total = 0;
   int bad   = 0;

   int   beat_m [2]   = '{0, 0};
   int   lcnt_m [2]   = '{0, 0};
   logic done_m [2]   = '{1'b0, 1'b0};
   int   ren_cnt [2]  = '{0, 0};
   int   done_cnt [2] = '{0, 0};
   int   popped [2]   = '{0, 0};
   logic hold_p [2]   = '{1'b0, 1'b0};
   logic [7:0] data_p [2];
   logic last_p [2];

   assign rempty[0] = (rd_idx[0] == wr_idx) || hold_empty;
   assign rempty[1] = (rd_idx[1] == wr_idx) || hold_empty;
   assign rdata[0]  = p1[0];
   assign rdata[1]  = p2[1];

   fifo_line_rd_stream #(.c_DATA_WIDTH(8), .c_RD_LATENCY(1), .c_LINE_LEN(LL), .c_BEAT_WIDTH(2)) u0 (
      .rclk(clk), .rrst_n(rrst_n), .rempty(rempty[0]), .r_en(r_en[0]), .rdata(rdata[0]),
      .frame_start(frame_start), .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
      .m_last(m_last[0]), .line_done(line_done[0]), .line_cnt(line_cnt[0]));

   fifo_line_rd_stream #(.c_DATA_WIDTH(8), .c_RD_LATENCY(2), .c_LINE_LEN(LL), .c_BEAT_WIDTH(2)) u1 (
      .rclk(clk), .rrst_n(rrst_n), .rempty(rempty[1]), .r_en(r_en[1]), .rdata(rdata[1]),
      .frame_start(frame_start), .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
      .m_last(m_last[1]), .line_done(line_done[1]), .line_cnt(line_cnt[1]));

   task automatic chk(input string nm, input int k, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, k, act, exp, $time);
      end
   endtask

   function automatic int q_size(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [7:0] q_pop(input int k);
      if (k == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   // RAM model: latency-1 stage p1, latency-2 stage p2
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (r_en[k]) begin
            p1[k]     <= mem[rd_idx[k] % 256];
            rd_idx[k] <= rd_idx[k] + 1;
         end
         p2[k] <= p1[k];
      end
   end

   // Monitor: scoreboard pops, framing model, protocol and occupancy checks
   always @(negedge clk) begin
      chk("occupancy", 0, int'(((32'(u0.count_r) + $countones(u0.trk_r)) <= 3)), 1);
      chk("occupancy", 1, int'(((32'(u1.count_r) + $countones(u1.trk_r)) <= 4)), 1);
      for (int k = 0; k < 2; k++) begin
         if (!rrst_n) begin
            chk("rst_r_en", k, r_en[k], 0);
            chk("rst_m_valid", k, m_valid[k], 0);
            chk("rst_line_cnt", k, line_cnt[k], 0);
            chk("rst_line_done", k, line_done[k], 0);
            beat_m[k] = 0;
            lcnt_m[k] = 0;
            done_m[k] = 1'b0;
            hold_p[k] = 1'b0;
         end else begin
            if (rempty[k]) chk("r_en_while_empty", k, r_en[k], 0);
            if (r_en[k]) ren_cnt[k]++;
            if (line_done[k]) done_cnt[k]++;
            chk("m_last", k, m_last[k], int'(m_valid[k] && (beat_m[k] == LL - 1)));
            chk("line_done", k, line_done[k], done_m[k]);
            chk("line_cnt", k, line_cnt[k], lcnt_m[k]);
            if (hold_p[k]) begin
               chk("hold_valid", k, m_valid[k], 1);
               chk("hold_data", k, m_data[k], data_p[k]);
               chk("hold_last", k, m_last[k], last_p[k]);
            end
            if (m_valid[k] && m_ready) begin
               if (q_size(k) == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_beat[%0d]: got data %0d expected no beat", k, m_data[k]);
               end else begin
                  chk("data", k, m_data[k], q_pop(k));
               end
               popped[k]++;
            end
            hold_p[k] = m_valid[k] && !m_ready;
            data_p[k] = m_data[k];
            last_p[k] = m_last[k];
            if (frame_start) begin
               beat_m[k] = 0;
               lcnt_m[k] = 0;
               done_m[k] = 1'b0;
            end else if (m_valid[k] && m_ready) begin
               if (beat_m[k] == LL - 1) begin
                  beat_m[k] = 0;
                  lcnt_m[k] = (lcnt_m[k] + 1) % 65536;
                  done_m[k] = 1'b1;
               end else begin
                  beat_m[k]++;
                  done_m[k] = 1'b0;
               end
            end else begin
               done_m[k] = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n);
      for (int i = 0; i < n; i++) begin
         mem[wr_idx % 256] = ser[7:0];
         q0.push_back(ser[7:0]);
         q1.push_back(ser[7:0]);
         wr_idx++;
         ser++;
      end
   endtask

   task automatic drain(input int lim);
      for (int i = 0; i < lim; i++) begin
         tick();
         if (q0.size() == 0 && q1.size() == 0) break;
      end
      chk("drain_left", 0, q0.size(), 0);
      chk("drain_left", 1, q1.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base_ren [2];
      int base_done [2];
      int win_bad [2];
      int lost;
      logic [15:0] pat;
      pat = 16'b1011_0110_1101_0011;
      rrst_n = 1'b0; frame_start = 1'b0; m_ready = 1'b0; hold_empty = 1'b0;

      // 1: reset with a non-empty FIFO
      repeat (2) tick();
      load(2);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("t1_r_en", k, r_en[k], 0);
         chk("t1_m_valid", k, m_valid[k], 0);
         chk("t1_line_cnt", k, line_cnt[k], 0);
      end
      @(posedge clk); #1;
      rrst_n = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("t1_r_en_release", k, r_en[k], 1);
      drain(20);
      repeat (3) tick();

      // 2: streaming 20 words, no backpressure
      load(20);
      base_ren = ren_cnt;
      win_bad = '{0, 0};
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++)
            if (m_valid[k] != ((c >= 2 + k) && (c < 22 + k))) win_bad[k]++;
      end
      for (int k = 0; k < 2; k++) begin
         chk("t2_valid_window", k, win_bad[k], 0);
         chk("t2_r_en_cycles", k, ren_cnt[k] - base_ren[k], 20);
      end
      drain(5);

      // 3: backpressure with a full FIFO
      m_ready = 1'b0;
      load(10);
      base_ren = ren_cnt;
      repeat (10) tick();
      chk("t3_r_en_pulses", 0, ren_cnt[0] - base_ren[0], 3);
      chk("t3_r_en_pulses", 1, ren_cnt[1] - base_ren[1], 4);
      m_ready = 1'b1;
      drain(60);
      repeat (2) tick();

      // 4: framing with an irregular ready pattern
      m_ready = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      base_done = done_cnt;
      load(12);
      for (int i = 0; i < 300; i++) begin
         m_ready = pat[i % 16];
         tick();
         if (q0.size() == 0 && q1.size() == 0) break;
      end
      m_ready = 1'b1;
      chk("t4_left", 0, q0.size() + q1.size(), 0);
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         chk("t4_done_pulses", k, done_cnt[k] - base_done[k], 3);
         chk("t4_line_cnt", k, line_cnt[k], 3);
      end

      // 5: frame_start coinciding with acceptance of beat 2
      m_ready = 1'b0;
      load(3);
      repeat (6) tick();
      base_done = done_cnt;
      m_ready = 1'b1;
      tick();
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         chk("t5_line_cnt", k, line_cnt[k], 0);
         chk("t5_no_done", k, done_cnt[k] - base_done[k], 0);
      end
      load(4);
      drain(40);
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         chk("t5_done_after4", k, done_cnt[k] - base_done[k], 1);
         chk("t5_line_cnt_after4", k, line_cnt[k], 1);
      end

      // 6a: rempty toggling every 3 cycles
      load(15);
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 0) hold_empty = ~hold_empty;
         tick();
      end
      hold_empty = 1'b0;
      drain(60);

      // 6b: reset with 3 beats buffered; those beats must never appear
      m_ready = 1'b0;
      load(3);
      repeat (6) tick();
      rrst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         lost = rd_idx[k] - popped[k];
         for (int j = 0; j < lost; j++) void'(q_pop(k));
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("t6_rst_m_valid", k, m_valid[k], 0);
         chk("t6_rst_r_en", k, r_en[k], 0);
      end
      repeat (2) tick();
      rrst_n = 1'b1;
      m_ready = 1'b1;
      load(4);
      drain(40);
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
